// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline status in, stall/flush controls out, between the datapath and the hazard controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       IFID_rs1;
  logic [4:0]       IFID_rs2;
  logic             IFID_uses_rs2;
  logic [4:0]       IDEX_rd;
  logic             IDEX_MemRead;
  logic             EXMEM_MemReq;
  logic             mem_ready;
  logic             branch_taken;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IDEX_Write;
  logic             EXMEM_Write;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_rd, IDEX_MemRead,
           EXMEM_MemReq, mem_ready, branch_taken,
    input  PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, IDEX_Bubble,
           IFID_Flush, IDEX_Flush, EXMEM_Flush, stall_count, flush_count
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_rd, IDEX_MemRead,
           EXMEM_MemReq, mem_ready, branch_taken,
    output PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, IDEX_Bubble,
           IFID_Flush, IDEX_Flush, EXMEM_Flush, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the five-stage RV64 pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait freezes and saturating event counters.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, STALL, MWAIT} state_t;

  state_t           state_q, state_d;
  logic             lu, mw;
  logic             do_freeze, do_flush, do_bubble;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign lu = bus.IDEX_MemRead && (bus.IDEX_rd != 5'd0) &&
              ((bus.IDEX_rd == bus.IFID_rs1) ||
               (bus.IFID_uses_rs2 && (bus.IDEX_rd == bus.IFID_rs2)));
  assign mw = bus.EXMEM_MemReq && !bus.mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN, MWAIT: begin
        if (mw)                    state_d = MWAIT;
        else if (bus.branch_taken) state_d = RUN;
        else if (lu)               state_d = STALL;
        else                       state_d = RUN;
      end
      STALL:   state_d = mw ? MWAIT : RUN;
      default: state_d = RUN;
    endcase
  end

  // Action decode; STALL skips the load-use term so a load yields one bubble.
  // Gated by reset so outputs are idle while reset is held.
  always_comb begin
    do_freeze = 1'b0;
    do_flush  = 1'b0;
    do_bubble = 1'b0;
    if (reset) begin
      case (state_q)
        RUN, MWAIT: begin
          if (mw)                    do_freeze = 1'b1;
          else if (bus.branch_taken) do_flush  = 1'b1;
          else if (lu)               do_bubble = 1'b1;
        end
        STALL: begin
          if (mw)                    do_freeze = 1'b1;
          else if (bus.branch_taken) do_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite     = !(do_freeze || do_bubble);
    bus.IFID_Write  = !(do_freeze || do_bubble);
    bus.IDEX_Write  = !do_freeze;
    bus.EXMEM_Write = !do_freeze;
    bus.IDEX_Bubble = do_bubble;
    bus.IFID_Flush  = do_flush;
    bus.IDEX_Flush  = do_flush;
    bus.EXMEM_Flush = do_flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((do_freeze || do_bubble) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (do_flush && (flush_q != '1))                 flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_hazard_stall_ctrl;

  localparam logic [7:0] IDLE = 8'b1111_0000;
  localparam logic [7:0] FRZ  = 8'b0000_0000;
  localparam logic [7:0] FLS  = 8'b1111_0111;
  localparam logic [7:0] LUS  = 8'b0011_1000;

  typedef struct {
    logic [7:0]  ctl;
    int unsigned sc;
    int unsigned fc;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int unsigned n_tests;
  int unsigned n_fail;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();
  hazard_stall_ctrl_if #(.CNT_W(4))  bus4 ();

  hazard_stall_ctrl #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  hazard_stall_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  assign bus4.IFID_rs1      = bus.IFID_rs1;
  assign bus4.IFID_rs2      = bus.IFID_rs2;
  assign bus4.IFID_uses_rs2 = bus.IFID_uses_rs2;
  assign bus4.IDEX_rd       = bus.IDEX_rd;
  assign bus4.IDEX_MemRead  = bus.IDEX_MemRead;
  assign bus4.EXMEM_MemReq  = bus.EXMEM_MemReq;
  assign bus4.mem_ready     = bus.mem_ready;
  assign bus4.branch_taken  = bus.branch_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic mr,
                      input logic mq, input logic rdy, input logic br,
                      input logic [7:0] ectl, input int unsigned esc, input int unsigned efc);
    exp_t e;
    @(posedge clk);
    #1;
    reset                 = rst;
    bus.IFID_rs1          = rs1;
    bus.IFID_rs2          = rs2;
    bus.IFID_uses_rs2     = u2;
    bus.IDEX_rd           = rd;
    bus.IDEX_MemRead      = mr;
    bus.EXMEM_MemReq      = mq;
    bus.mem_ready         = rdy;
    bus.branch_taken      = br;
    e.ctl = ectl;
    e.sc  = esc;
    e.fc  = efc;
    q.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle, so each pushed vector is checked on the following negedge.
  initial begin
    exp_t e;
    logic [7:0] ctl;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        ctl = {bus.PCWrite, bus.IFID_Write, bus.IDEX_Write, bus.EXMEM_Write,
               bus.IDEX_Bubble, bus.IFID_Flush, bus.IDEX_Flush, bus.EXMEM_Flush};
        check("ctl", 32'(ctl), 32'(e.ctl));
        check("stall_count", 32'(bus.stall_count), e.sc);
        check("flush_count", 32'(bus.flush_count), e.fc);
        check("stall_count4", 32'(bus4.stall_count), (e.sc > 15) ? 15 : e.sc);
        check("flush_count4", 32'(bus4.flush_count), (e.fc > 15) ? 15 : e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.IFID_rs1 = '0; bus.IFID_rs2 = '0; bus.IFID_uses_rs2 = 1'b0;
    bus.IDEX_rd = '0; bus.IDEX_MemRead = 1'b0; bus.EXMEM_MemReq = 1'b0;
    bus.mem_ready = 1'b1; bus.branch_taken = 1'b0;

    //   rst rs1 rs2 u2 rd mr mq rdy br  ctl  sc fc
    step(0, 5, 0, 0, 5, 1, 1, 0, 1, IDLE, 0, 0);  // reset holds outputs idle
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, LUS,  0, 0);  // load-use
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, IDLE, 1, 0);  // one bubble only
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 1, 0);
    step(1, 0, 7, 0, 7, 1, 0, 1, 0, IDLE, 1, 0);  // rs2 not used
    step(1, 0, 7, 1, 7, 1, 0, 1, 0, LUS,  1, 0);  // rs2 used
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 2, 0);
    step(1, 0, 0, 1, 0, 1, 0, 1, 0, IDLE, 2, 0);  // x0 never stalls
    step(1, 5, 0, 0, 5, 1, 0, 1, 1, FLS,  2, 0);  // branch beats load-use
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 2, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  2, 1);  // 3-cycle memory wait
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  3, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  4, 1);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, IDLE, 5, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 5, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,  5, 1);  // branch held during wait
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,  6, 1);
    step(1, 0, 0, 0, 0, 0, 1, 1, 1, FLS,  7, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 7, 2);
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, LUS,  7, 2);  // stall then memory wait
    step(1, 5, 0, 0, 5, 1, 1, 0, 0, FRZ,  8, 2);
    step(1, 5, 0, 0, 5, 1, 1, 1, 0, LUS,  9, 2);  // wait exit applies load-use
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 10, 2);
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, LUS,  10, 2); // branch in stall cycle
    step(1, 5, 0, 0, 5, 1, 0, 1, 1, FLS,  11, 2);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 11, 3);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  11, 3); // reset mid-wait
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, IDLE, 0, 0);
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, LUS,  0, 0);  // back in RUN; reset mid-stall
    step(0, 5, 0, 0, 5, 1, 0, 1, 0, IDLE, 0, 0);
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, LUS,  0, 0);  // bubble again, so state was RUN
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 1, 0);
    for (int i = 0; i < 20; i++)
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 32'(1 + i), 0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, IDLE, 21, 0); // 4-bit counter pinned at 15
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, IDLE, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, 0, 0);

    @(posedge clk);
    @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 64-bit five-stage RISC-V core.
- Consumes the ID/EX register's outputs (destination register, memory-read control bit) together with IF/ID source registers and EX/MEM status.
- Drives the write-enable, bubble and flush controls back into PC, IF/ID, ID/EX and EX/MEM.
- Handles load-use stalls, taken-branch flushes, multi-cycle data-memory waits, and keeps saturating stall/flush counters.

Parameters:
CNT_W, 16, width of the stall and flush event counters (saturating).

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
IFID_rs1  input  5  rs1 field of the instruction in IF/ID
IFID_rs2  input  5  rs2 field of the instruction in IF/ID
IFID_uses_rs2  input  1  1 when the IF/ID instruction reads rs2 (R, S, SB types)
IDEX_rd  input  5  rd held in ID/EX
IDEX_MemRead  input  1  MemRead control bit held in ID/EX
EXMEM_MemReq  input  1  EX/MEM instruction accesses data memory (MemRead or MemWrite)
mem_ready  input  1  data memory has completed the current access
branch_taken  input  1  branch resolved taken in MEM stage
PCWrite  output  1  PC update enable
IFID_Write  output  1  IF/ID load enable
IDEX_Write  output  1  ID/EX load enable
EXMEM_Write  output  1  EX/MEM load enable
IDEX_Bubble  output  1  zero WB/M/EX controls loaded into ID/EX
IFID_Flush  output  1  clear IF/ID to NOP
IDEX_Flush  output  1  clear ID/EX controls
EXMEM_Flush  output  1  clear EX/MEM controls
stall_count  output  CNT_W  cycles spent in load-use stall or memory wait
flush_count  output  CNT_W  number of taken-branch flush events

Behaviour:
- Reset:
  - Reset is low, asynchronous: state=RUN, counters=0.
  - All control outputs are forced to RUN-idle values: all *_Write=1, Bubble=0, all Flush=0, independent of other inputs.
- States: RUN, STALL, MWAIT. State is registered. Control outputs are combinational from state and current inputs (same-cycle response).
- Load-use hazard (LU) = IDEX_MemRead && IDEX_rd!=0 && (IDEX_rd==IFID_rs1 || (IFID_uses_rs2 && IDEX_rd==IFID_rs2)).
- Memory wait (MW) = EXMEM_MemReq && !mem_ready.
- Priority within a cycle: MW > branch_taken > LU.
- RUN behaviour:
  - MW: all four *_Write=0, no flush, no bubble. Next state = MWAIT. stall_count++.
  - Else branch_taken: IFID_Flush=IDEX_Flush=EXMEM_Flush=1, writes=1. Next state = RUN. flush_count++. Any LU in the same cycle is discarded.
  - Else LU: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IDEX_Write=1, EXMEM_Write=1. Next state = STALL. stall_count++.
  - Else: idle values, stay in RUN.
- STALL behaviour (exactly one cycle):
  - LU is not re-evaluated, so at most one bubble per load.
  - MW and branch_taken are handled as in RUN; otherwise idle values.
  - Next state = MWAIT if MW, else RUN.
- MWAIT behaviour:
  - Full freeze (all *_Write=0) while MW holds; stall_count++ each cycle.
  - branch_taken is ignored while frozen. Because EX/MEM is frozen, the branch remains present and is flushed in the first cycle mem_ready=1.
  - When mem_ready=1: leave the freeze this cycle, applying branch_taken, then LU, then idle as in RUN. Next state per the RUN rules.
- Counters: unsigned, saturate at 2^CNT_W-1, never wrap.
- Reset asserted mid-MWAIT or mid-STALL: state immediately RUN, counters cleared. No pending bubble or flush survives.
- IDEX_rd==0 never causes a stall (x0 is never a real dependency).

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs1=5 -> one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Next cycle (inputs unchanged) idle values. stall_count=1.
- rs2 masking: IDEX_rd=7, IFID_rs2=7, IFID_uses_rs2=0 -> no stall. Same stimulus with IFID_uses_rs2=1 -> stall. IDEX_rd=0 matching rs1 -> no stall.
- Branch vs load-use same cycle: branch_taken=1 and LU=1 -> three flushes=1, IDEX_Bubble=0, flush_count=1, stall_count unchanged.
- Memory wait: EXMEM_MemReq=1, mem_ready=0 for 3 cycles, then 1 -> writes=0 for 3 cycles, stall_count=3, writes=1 on the fourth cycle.
- Branch during wait: branch_taken=1 throughout a 2-cycle wait -> no flush during the wait, flushes asserted in the mem_ready=1 cycle, flush_count=1.
- Reset and saturation: CNT_W=4 with 20 stall cycles -> stall_count=15. Assert reset mid-MWAIT -> counters=0, outputs idle, state RUN after release.
